// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and load/store.
// LS has priority; a wait counter forces an IF win after MAX_WAIT denied cycles.
module mem_port_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                MAX_WAIT = 4,
    parameter logic [DATA_W-1:0] NOP_INS  = 32'h00000013
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                if_rready_i,
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W/8-1:0] ls_sel_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    output logic                ls_gnt_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,
    input  logic                ls_rready_i,
    output logic                mem_ce_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W/8-1:0] mem_sel_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);
    localparam int SEL_W = DATA_W / 8;

    typedef struct packed {
        logic              ce;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    logic [3:0]        wait_cnt;
    logic              if_rvalid_q, ls_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
    logic              if_elig, ls_elig, starved;
    logic              if_gnt, ls_gnt;
    mem_req_t          mreq;

    // A response slot being drained this cycle can accept the next access.
    assign if_elig = if_req_i & (~if_rvalid_q | if_rready_i);
    assign ls_elig = ls_req_i & (~ls_rvalid_q | ls_rready_i);
    assign starved = wait_cnt >= 4'(MAX_WAIT);

    assign if_gnt = ~rst_i & if_elig & (starved | ~ls_elig);
    assign ls_gnt = ~rst_i & ls_elig & ~if_gnt;

    always_comb begin
        mreq = '0;
        if (ls_gnt) begin
            mreq.ce    = 1'b1;
            mreq.we    = ls_we_i;
            mreq.addr  = ls_addr_i;
            mreq.sel   = ls_sel_i;
            mreq.wdata = ls_we_i ? ls_wdata_i : '0;
        end else if (if_gnt) begin
            mreq.ce   = 1'b1;
            mreq.addr = if_addr_i;
            mreq.sel  = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt    <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            if (if_gnt || !if_req_i)
                wait_cnt <= '0;
            else if (if_elig && wait_cnt != 4'hF)
                wait_cnt <= wait_cnt + 4'd1;

            if (if_gnt) begin
                if_rvalid_q <= 1'b1;
                if_rdata_q  <= mem_rdata_i;
            end else if (if_rready_i && if_rvalid_q) begin
                if_rvalid_q <= 1'b0;
            end

            // Writes are acknowledged with zero data.
            if (ls_gnt) begin
                ls_rvalid_q <= 1'b1;
                ls_rdata_q  <= ls_we_i ? '0 : mem_rdata_i;
            end else if (ls_rready_i && ls_rvalid_q) begin
                ls_rvalid_q <= 1'b0;
            end
        end
    end

    assign if_gnt_o    = if_gnt;
    assign ls_gnt_o    = ls_gnt;
    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rvalid_q ? if_rdata_q : NOP_INS;
    assign ls_rvalid_o = ls_rvalid_q;
    assign ls_rdata_o  = ls_rvalid_q ? ls_rdata_q : '0;
    assign mem_ce_o    = mreq.ce;
    assign mem_we_o    = mreq.we;
    assign mem_addr_o  = mreq.addr;
    assign mem_sel_o   = mreq.sel;
    assign mem_wdata_o = mreq.wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, starvation sequence, and
// randomized traffic against a queue-based reference model with a shadow RAM.
module tb_mem_port_arbiter;
    localparam int MW = 4;

    logic        clk;
    logic        rst, if_req, if_rready, ls_req, ls_we, ls_rready;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [3:0]  ls_sel;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_ce, mem_we;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_sel;

    logic [31:0] ram [256];
    logic [31:0] ref_mem [256];

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW), .NOP_INS(32'h13)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_rready_i(if_rready),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_sel_i(ls_sel),
        .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid),
        .ls_rdata_o(ls_rdata), .ls_rready_i(ls_rready),
        .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_sel_o(mem_sel), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM: combinational read, byte-enabled write on the edge.
    assign mem_rdata = ram[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_ce && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_sel[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    // ---------------- reference model ----------------
    logic [31:0] ifq[$], lsq[$];
    int          m_wait;
    bit          m_if_ok, m_ls_ok, m_ifg, m_lsg;

    task automatic model_decide();
        m_if_ok = if_req && (ifq.size() == 0 || if_rready);
        m_ls_ok = ls_req && (lsq.size() == 0 || ls_rready);
        m_ifg = 0;
        m_lsg = 0;
        if (!rst) begin
            if (m_wait >= MW) begin
                if (m_if_ok) m_ifg = 1; else if (m_ls_ok) m_lsg = 1;
            end else begin
                if (m_ls_ok) m_lsg = 1; else if (m_if_ok) m_ifg = 1;
            end
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            ifq.delete();
            lsq.delete();
            m_wait = 0;
            return;
        end
        if (m_ifg) begin
            ifq.delete();
            ifq.push_back(ref_mem[if_addr[9:2]]);
        end else if (if_rready && ifq.size() != 0) ifq.delete();
        if (m_lsg) begin
            lsq.delete();
            if (ls_we) begin
                lsq.push_back(32'h0);
                for (int b = 0; b < 4; b++)
                    if (ls_sel[b]) ref_mem[ls_addr[9:2]][8*b +: 8] = ls_wdata[8*b +: 8];
            end else lsq.push_back(ref_mem[ls_addr[9:2]]);
        end else if (ls_rready && lsq.size() != 0) lsq.delete();
        if (m_ifg || !if_req) m_wait = 0;
        else if (m_if_ok) m_wait = (m_wait + 1 > 15) ? 15 : m_wait + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_sel;
        e_addr = m_lsg ? ls_addr : (m_ifg ? if_addr : 32'h0);
        e_sel  = m_lsg ? ls_sel : (m_ifg ? 4'hF : 4'h0);
        e_wd   = (m_lsg && ls_we) ? ls_wdata : 32'h0;
        chk({tag, ".if_gnt"}, 32'(if_gnt), 32'(m_ifg));
        chk({tag, ".ls_gnt"}, 32'(ls_gnt), 32'(m_lsg));
        chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(ifq.size() != 0));
        chk({tag, ".if_rdata"}, if_rdata, ifq.size() != 0 ? ifq[0] : 32'h13);
        chk({tag, ".ls_rvalid"}, 32'(ls_rvalid), 32'(lsq.size() != 0));
        chk({tag, ".ls_rdata"}, ls_rdata, lsq.size() != 0 ? lsq[0] : 32'h0);
        chk({tag, ".mem_ce"}, 32'(mem_ce), 32'(m_ifg | m_lsg));
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(m_lsg & ls_we));
        chk({tag, ".mem_addr"}, mem_addr, e_addr);
        chk({tag, ".mem_sel"}, 32'(mem_sel), 32'(e_sel));
        chk({tag, ".mem_wdata"}, mem_wdata, e_wd);
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, ifr;
        logic [31:0] ifa;
        logic        ifrr, lsr, lswe;
        logic [31:0] lsa;
        logic [3:0]  lssel;
        logic [31:0] lswd;
        logic        lsrr;
        logic        e_ifg, e_lsg, e_ifv;
        logic [31:0] e_ifd;
        logic        e_lsv;
        logic [31:0] e_lsd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ifr, input logic [31:0] ifa, input logic ifrr,
                       input logic lsr, input logic lswe, input logic [31:0] lsa,
                       input logic [3:0] lssel, input logic [31:0] lswd, input logic lsrr,
                       input logic eig, input logic elg, input logic eiv, input logic [31:0] eid,
                       input logic elv, input logic [31:0] eld);
        vec_t v;
        v = '{r, ifr, ifa, ifrr, lsr, lswe, lsa, lssel, lswd, lsrr, eig, elg, eiv, eid, elv, eld};
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; if_req = v.ifr; if_addr = v.ifa; if_rready = v.ifrr;
        ls_req = v.lsr; ls_we = v.lswe; ls_addr = v.lsa; ls_sel = v.lssel;
        ls_wdata = v.lswd; ls_rready = v.lsrr;
    endtask

    bit if_pend, ls_pend;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 | 32'(i);
        ram[17] = 32'h1122_3344;
        for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
        m_wait = 0;

        // reset state
        apply('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0});
        #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            model_decide();
            chk("rst.if_gnt", 32'(if_gnt), 32'h0);
            chk("rst.ls_gnt", 32'(ls_gnt), 32'h0);
            chk("rst.mem_ce", 32'(mem_ce), 32'h0);
            if (c == 1) begin
                chk("rst.if_rvalid", 32'(if_rvalid), 32'h0);
                chk("rst.if_rdata", if_rdata, 32'h13);
                chk("rst.ls_rvalid", 32'(ls_rvalid), 32'h0);
                chk("rst.ls_rdata", ls_rdata, 32'h0);
            end
            at_pos();
        end

        // rst ifr ifa ifrr lsr we lsa sel wd lsrr | ifg lsg ifv ifd lsv lsd
        // IF streaming
        add(0,1,32'h0,1, 0,0,0,0,0,1,  1,0, 0,32'h13,        0,0);
        add(0,1,32'h4,1, 0,0,0,0,0,1,  1,0, 1,32'hA0000000,  0,0);
        add(0,1,32'h8,1, 0,0,0,0,0,1,  1,0, 1,32'hA0000001,  0,0);
        add(0,0,32'h0,1, 0,0,0,0,0,1,  0,0, 1,32'hA0000002,  0,0);
        add(0,0,32'h0,1, 0,0,0,0,0,1,  0,0, 0,32'h13,        0,0);
        // LS write then IF reads it next cycle
        add(0,0,32'h0,1, 1,1,32'h100,4'hF,32'hDEADBEEF,1, 0,1, 0,32'h13, 0,0);
        add(0,1,32'h100,1, 0,0,0,0,0,0, 1,0, 0,32'h13,       1,0);
        add(0,0,32'h0,0, 0,0,0,0,0,1,  0,0, 1,32'hDEADBEEF,  1,0);
        // IF response held, LS still served; IF re-granted on rready
        add(0,1,32'h0,0, 1,0,32'h4,0,0,1, 0,1, 1,32'hDEADBEEF, 0,0);
        add(0,1,32'h0,0, 0,0,0,0,0,1,  0,0, 1,32'hDEADBEEF,  1,32'hA0000001);
        add(0,1,32'h0,1, 0,0,0,0,0,1,  1,0, 1,32'hDEADBEEF,  0,0);
        add(0,0,32'h0,1, 0,0,0,0,0,1,  0,0, 1,32'hA0000000,  0,0);
        // byte-select write
        add(0,0,32'h0,1, 1,1,32'h44,4'b0010,32'hAABBCCDD,1, 0,1, 0,32'h13, 0,0);
        add(0,0,32'h0,1, 1,0,32'h44,0,0,1, 0,1, 0,32'h13,    1,0);
        add(0,0,32'h0,1, 0,0,0,0,0,1,  0,0, 0,32'h13,        1,32'h1122CC44);
        add(0,0,32'h0,1, 0,0,0,0,0,1,  0,0, 0,32'h13,        0,0);
        // reset with both responses held
        add(0,1,32'h8,0, 1,0,32'hC,0,0,0, 0,1, 0,32'h13,     0,0);
        add(0,1,32'h8,0, 0,0,0,0,0,0,  1,0, 0,32'h13,        1,32'hA0000003);
        add(0,0,32'h0,0, 0,0,0,0,0,0,  0,0, 1,32'hA0000002,  1,32'hA0000003);
        add(1,1,32'h0,0, 1,0,32'h0,0,0,0, 0,0, 1,32'hA0000002, 1,32'hA0000003);
        add(0,0,32'h0,0, 0,0,0,0,0,0,  0,0, 0,32'h13,        0,0);

        foreach (vecs[i]) begin
            apply(vecs[i]);
            @(negedge clk);
            model_decide();
            chk($sformatf("v%0d.if_gnt", i), 32'(if_gnt), 32'(vecs[i].e_ifg));
            chk($sformatf("v%0d.ls_gnt", i), 32'(ls_gnt), 32'(vecs[i].e_lsg));
            chk($sformatf("v%0d.mem_ce", i), 32'(mem_ce), 32'(vecs[i].e_ifg | vecs[i].e_lsg));
            chk($sformatf("v%0d.if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].e_ifv));
            chk($sformatf("v%0d.if_rdata", i), if_rdata, vecs[i].e_ifd);
            chk($sformatf("v%0d.ls_rvalid", i), 32'(ls_rvalid), 32'(vecs[i].e_lsv));
            chk($sformatf("v%0d.ls_rdata", i), ls_rdata, vecs[i].e_lsd);
            at_pos();
        end

        // starvation: LS wins MW cycles, then IF once, repeating
        rst = 0; if_req = 1; if_addr = 32'h10; if_rready = 1;
        ls_req = 1; ls_we = 0; ls_addr = 32'h20; ls_sel = 4'h0; ls_wdata = 0; ls_rready = 1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            model_decide();
            chk($sformatf("starve%0d.if_gnt", k), 32'(if_gnt), 32'(k % (MW + 1) == MW));
            chk($sformatf("starve%0d.ls_gnt", k), 32'(ls_gnt), 32'(k % (MW + 1) != MW));
            at_pos();
        end

        // randomized traffic against the model
        if_pend = 0; ls_pend = 0;
        if_req = 0; ls_req = 0;
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(99, 0) == 0);
            if_rready = ($urandom_range(3, 0) != 0);
            ls_rready = ($urandom_range(3, 0) != 0);
            if (!if_pend && $urandom_range(3, 0) != 0) begin
                if_pend = 1;
                if_addr = 32'($urandom_range(255, 0)) << 2;
            end
            if (!ls_pend && $urandom_range(3, 0) != 0) begin
                ls_pend  = 1;
                ls_we    = $urandom_range(1, 0) == 1;
                ls_addr  = 32'($urandom_range(255, 0)) << 2;
                ls_sel   = 4'($urandom);
                ls_wdata = $urandom;
            end
            if_req = if_pend;
            ls_req = ls_pend;
            @(negedge clk);
            model_decide();
            check_model($sformatf("rnd%0d", c));
            at_pos();
            if (rst) begin
                if_pend = 0;
                ls_pend = 0;
            end else begin
                if (m_ifg) if_pend = 0;
                if (m_lsg) ls_pend = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
